// File: rtl/elbeth_pkg.sv
// Shared definitions for the ELBETH pipeline stage registers: default
// payload widths, the bubble instruction and the stage occupancy states.
package elbeth_pkg;

  localparam int          DEF_INSTR_W   = 32;
  localparam int          DEF_PC_W      = 32;
  localparam int          DEF_SIDE_W    = 8;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

  // EMPTY: nothing held; ONE: main entry held; FULL: main and skid held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

endpackage

// File: rtl/elbeth_pipe_slot.sv
// One payload register with a valid bit. The valid bit follows valid_d on
// every edge; the payload only changes when load is asserted.
module elbeth_pipe_slot #(
  parameter int W = 72
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         valid_d,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // Valid bit: cleared immediately by reset, otherwise tracks valid_d.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) valid <= 1'b0;
    else        valid <= valid_d;
  end

  // Payload: captured on load only.
  always_ff @(posedge clk) begin
    // NOTE: the payload is deliberately not reset; nothing observes it
    // while valid is low, and dropping the reset keeps the datapath flops
    // plain enables.
    if (load) q <= d;
  end

endmodule

// File: rtl/elbeth_pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, stall, flush, bubble
// (NOP) insertion and an optional two-entry skid buffer that makes up_ready
// a registered signal.
module elbeth_pipe_stage_reg
  import elbeth_pkg::*;
#(
  parameter int                 INSTR_W   = DEF_INSTR_W,
  parameter int                 PC_W      = DEF_PC_W,
  parameter int                 SIDE_W    = DEF_SIDE_W,
  parameter bit                 SKID_EN   = 1'b1,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEF_NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [INSTR_W-1:0] up_instruction,
  input  logic [PC_W-1:0]    up_pc,
  input  logic [SIDE_W-1:0]  up_side,
  input  logic               ctrl_stall,
  input  logic               ctrl_flush,
  output logic               dn_valid,
  input  logic               dn_ready,
  output logic [INSTR_W-1:0] dn_instruction,
  output logic [PC_W-1:0]    dn_pc,
  output logic [SIDE_W-1:0]  dn_side,
  output logic [1:0]         occ
);

  localparam int PAY_W = INSTR_W + PC_W + SIDE_W;

  stage_state_t     state_q, state_d;
  logic             out_of_reset_q;
  logic             up_fire, dn_fire;
  logic             main_load, skid_load, main_from_skid;
  logic             main_valid, skid_valid;
  logic [PAY_W-1:0] up_payload, main_d, main_q, skid_q;

  assign up_payload = {up_instruction, up_pc, up_side};
  assign dn_fire    = main_valid & dn_ready & ~ctrl_stall;
  assign up_fire    = up_valid & up_ready;

  // Out-of-reset marker: holds up_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_of_reset_q <= 1'b0;
    else        out_of_reset_q <= 1'b1;
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next-state and slot load decode; flush overrides every other event.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (ctrl_flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (up_fire) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (up_fire && dn_fire) begin
            main_load = 1'b1;
          end else if (up_fire && SKID_EN) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (dn_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (dn_fire) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : up_payload;

  elbeth_pipe_slot #(.W(PAY_W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (main_load),
    .valid_d (state_d != EMPTY),
    .d       (main_d),
    .valid   (main_valid),
    .q       (main_q)
  );

  if (SKID_EN) begin : g_skid
    elbeth_pipe_slot #(.W(PAY_W)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (skid_load),
      .valid_d (state_d == FULL),
      .d       (up_payload),
      .valid   (skid_valid),
      .q       (skid_q)
    );
    // Ready depends only on flops, so dn_ready/ctrl_stall never reach it.
    assign up_ready = out_of_reset_q & (state_q != FULL);
  end else begin : g_no_skid
    logic unused_skid_load;
    assign unused_skid_load = skid_load;
    assign skid_valid       = 1'b0;
    assign skid_q           = '0;
    // Single entry: accept only when the held entry leaves this cycle.
    assign up_ready = out_of_reset_q & (~main_valid | (dn_ready & ~ctrl_stall));
  end

  assign occ            = {1'b0, main_valid} + {1'b0, skid_valid};
  assign dn_valid       = main_valid;
  assign dn_instruction = main_valid ? main_q[PAY_W-1 -: INSTR_W] : NOP_INSTR;
  assign dn_pc          = main_valid ? main_q[SIDE_W +: PC_W]     : '0;
  assign dn_side        = main_valid ? main_q[SIDE_W-1:0]         : '0;

endmodule

// File: tb/tb_elbeth_pipe_stage_reg.sv
// Bench for elbeth_pipe_stage_reg: a skid instance driven from a vector
// table with a transfer scoreboard, plus a single-entry instance used for
// the combinational-ready stall sequence.
module tb_elbeth_pipe_stage_reg;

  logic        clk, rst_n;
  logic        up_valid, u0_valid;
  logic [31:0] up_instruction, up_pc;
  logic [7:0]  up_side;
  logic        dn_ready, ctrl_stall, ctrl_flush;

  logic        up_ready, dn_valid;
  logic [31:0] dn_instruction, dn_pc;
  logic [7:0]  dn_side;
  logic [1:0]  occ;

  logic        up_ready0, dn_valid0;
  logic [31:0] dn_instruction0, dn_pc0;
  logic [7:0]  dn_side0;
  logic [1:0]  occ0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [7:0]  side;
  } pay_t;

  pay_t sb[$];

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        rdy;
    logic        stall;
    logic        flush;
    logic        e_dv;
    logic [1:0]  e_occ;
    logic        e_ur;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[20];

  elbeth_pipe_stage_reg #(.SKID_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid), .up_ready(up_ready),
    .up_instruction(up_instruction), .up_pc(up_pc), .up_side(up_side),
    .ctrl_stall(ctrl_stall), .ctrl_flush(ctrl_flush),
    .dn_valid(dn_valid), .dn_ready(dn_ready),
    .dn_instruction(dn_instruction), .dn_pc(dn_pc), .dn_side(dn_side),
    .occ(occ)
  );

  elbeth_pipe_stage_reg #(.SKID_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .up_valid(u0_valid), .up_ready(up_ready0),
    .up_instruction(up_instruction), .up_pc(up_pc), .up_side(up_side),
    .ctrl_stall(ctrl_stall), .ctrl_flush(ctrl_flush),
    .dn_valid(dn_valid0), .dn_ready(dn_ready),
    .dn_instruction(dn_instruction0), .dn_pc(dn_pc0), .dn_side(dn_side0),
    .occ(occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {~pc[15:0], pc[15:0]};
  endfunction

  function automatic logic [7:0] side_of(input logic [31:0] pc);
    return pc[9:2];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_pc(input logic [31:0] pc);
    up_pc          = pc;
    up_instruction = instr_of(pc);
    up_side        = side_of(pc);
  endtask

  // Output check of the skid instance against an expected entry (or bubble).
  task automatic check_out(input string tag, input logic e_dv, input logic [1:0] e_occ,
                           input logic e_ur, input logic [31:0] e_pc);
    check({tag, "_dn_valid"}, 64'(dn_valid), 64'(e_dv));
    check({tag, "_occ"},      64'(occ),      64'(e_occ));
    check({tag, "_up_ready"}, 64'(up_ready), 64'(e_ur));
    check({tag, "_dn_pc"},    64'(dn_pc),    64'(e_dv ? e_pc : 32'h0));
    check({tag, "_dn_instr"}, 64'(dn_instruction),
          64'(e_dv ? instr_of(e_pc) : 32'h0000_0013));
    check({tag, "_dn_side"},  64'(dn_side),  64'(e_dv ? side_of(e_pc) : 8'h0));
  endtask

  // One clock: score transfers of the skid instance, then sample after the edge.
  task automatic step();
    logic upf, dnf;
    pay_t e;
    #1;
    upf = up_valid & up_ready;
    dnf = dn_valid & dn_ready & ~ctrl_stall;
    if (ctrl_flush) begin
      sb.delete();
    end else begin
      if (dnf) begin
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_pc",    64'(dn_pc),          64'(e.pc));
          check("sb_instr", 64'(dn_instruction), 64'(e.instr));
          check("sb_side",  64'(dn_side),        64'(e.side));
        end
      end
      if (upf) sb.push_back('{instr: up_instruction, pc: up_pc, side: up_side});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          v     pc           rdy   stl   fl    dv    occ   ur    exp pc
    vecs[0]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h100}; // stream
    vecs[1]  = '{1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h104};
    vecs[2]  = '{1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h108};
    vecs[3]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'h000};
    vecs[4]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h100}; // skid fill
    vecs[5]  = '{1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h100};
    vecs[6]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h200};
    vecs[7]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'h000};
    vecs[8]  = '{1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h400}; // stall
    vecs[9]  = '{1'b1, 32'h404, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h400};
    vecs[10] = '{1'b1, 32'h408, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h400};
    vecs[11] = '{1'b1, 32'h408, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h400};
    vecs[12] = '{1'b1, 32'h408, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h404};
    vecs[13] = '{1'b1, 32'h408, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h404}; // flush
    vecs[14] = '{1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h000};
    vecs[15] = '{1'b1, 32'h304, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h304};
    vecs[16] = '{1'b1, 32'h308, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h000};
    vecs[17] = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'h000};
    vecs[18] = '{1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h500}; // refill
    vecs[19] = '{1'b1, 32'h504, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h500};

    rst_n = 1'b0; up_valid = 1'b0; u0_valid = 1'b0;
    dn_ready = 1'b0; ctrl_stall = 1'b0; ctrl_flush = 1'b0;
    set_pc(32'h0);

    // Reset and bubble.
    repeat (2) @(posedge clk);
    #1;
    check_out("rst", 1'b0, 2'd0, 1'b0, 32'h0);
    check("rst_dn_valid0", 64'(dn_valid0), 64'd0);
    check("rst_dn_instr0", 64'(dn_instruction0), 64'h13);
    check("rst_up_ready0", 64'(up_ready0), 64'd0);
    #2 rst_n = 1'b1;
    #1;
    check("rel_up_ready_before_edge", 64'(up_ready), 64'd0);
    @(posedge clk);
    #1;
    check("rel_up_ready_after_edge",  64'(up_ready),  64'd1);
    check("rel_up_ready0_after_edge", 64'(up_ready0), 64'd1);

    // Vector table on the skid instance.
    for (int i = 0; i < 20; i++) begin
      up_valid   = vecs[i].v;
      set_pc(vecs[i].pc);
      dn_ready   = vecs[i].rdy;
      ctrl_stall = vecs[i].stall;
      ctrl_flush = vecs[i].flush;
      step();
      check_out($sformatf("vec%0d", i), vecs[i].e_dv, vecs[i].e_occ,
                vecs[i].e_ur, vecs[i].e_pc);
    end

    // Async reset between edges while FULL.
    up_valid = 1'b0; ctrl_flush = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 2'd0, 1'b0, 32'h0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("async_rel_up_ready", 64'(up_ready), 64'd1);

    // Single-entry instance: stall drops up_ready in the same cycle.
    u0_valid = 1'b1; set_pc(32'h600); dn_ready = 1'b1; ctrl_stall = 1'b0;
    step();
    check("ns_load_dn_valid", 64'(dn_valid0), 64'd1);
    check("ns_load_dn_pc",    64'(dn_pc0),    64'h600);
    check("ns_load_up_ready", 64'(up_ready0), 64'd1);
    set_pc(32'h604);
    ctrl_stall = 1'b1;
    #1;
    check("ns_stall_up_ready_same_cycle", 64'(up_ready0), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("ns_stall%0d_dn_pc", k),    64'(dn_pc0),          64'h600);
      check($sformatf("ns_stall%0d_dn_instr", k), 64'(dn_instruction0), 64'(instr_of(32'h600)));
      check($sformatf("ns_stall%0d_occ", k),      64'(occ0),            64'd1);
      check($sformatf("ns_stall%0d_up_ready", k), 64'(up_ready0),       64'd0);
    end
    ctrl_stall = 1'b0;
    #1;
    check("ns_unstall_up_ready", 64'(up_ready0), 64'd1);
    step();
    check("ns_next_dn_pc",   64'(dn_pc0),   64'h604);
    check("ns_next_dn_side", 64'(dn_side0), 64'(side_of(32'h604)));
    u0_valid = 1'b0;
    step();
    check("ns_drain_dn_valid", 64'(dn_valid0),       64'd0);
    check("ns_drain_dn_instr", 64'(dn_instruction0), 64'h13);
    check("ns_drain_occ",      64'(occ0),            64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
